crc_stream: RTL and testbench
=============================

CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 The block SHALL take parameter WCODE, default 4, as the data word width in bits.
REQ-002 The block SHALL take parameter WPOLY, default 3, as the generator polynomial width including the implicit MSB term; the CRC width is WPOLY-1.
REQ-003 The block SHALL take parameter BPC, default 1, as the data bits processed per clock; WCODE % BPC == 0 and WPOLY >= 2 SHALL be checked at elaboration, with a fatal error on violation.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset, with ports in this order:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  block can accept a word.
- i_data  in  WCODE  data word, processed MSB first.
- i_first  in  1  word opens a frame.
- i_last  in  1  word closes a frame.
- i_poly  in  WPOLY  generator polynomial.
- i_init  in  WPOLY-1  CRC seed loaded at frame start.
- o_crc  out  WPOLY-1  frame CRC result.
- o_valid  out  1  o_crc valid.
- i_ready  in  1  consumer accepts the result.
- i_crc_ref  in  WPOLY-1  expected CRC (CRC_CHECK_EN builds only).
- o_match  out  1  o_crc == i_crc_ref (CRC_CHECK_EN builds only).

Function
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-006 o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-007 A word SHALL be accepted on a rising edge with i_valid & o_ready; at that edge:
- i_data loads into the shift register;
- the chunk counter loads WCODE/BPC;
- the FSM moves to SHIFT;
- i_last is latched.
REQ-008 If i_first is set on the accepted word, the CRC register SHALL load i_init and the polynomial register SHALL load i_poly on the same edge; otherwise both SHALL keep their values (the frame continues).
REQ-009 Each SHIFT cycle SHALL apply BPC single-bit LFSR steps, MSB first; one step is fb = crc[MSB] ^ d, then crc = (crc << 1) ^ (fb ? poly[WPOLY-2:0] : 0).
REQ-010 After WCODE/BPC SHIFT cycles the FSM SHALL go to DONE if the latched i_last is 1, else to IDLE.
REQ-011 Latency and throughput:
- o_valid, or o_ready for a non-last word, SHALL rise exactly WCODE/BPC edges after the accept edge;
- the maximum rate SHALL be one word per WCODE/BPC+1 cycles.
REQ-012 DONE SHALL hold o_crc and o_valid stable until i_ready=1, then return to IDLE on that edge.
REQ-013 o_crc SHALL always show the CRC register, and a frame's result SHALL equal the remainder of (seed-adjusted message · x^(WPOLY-1)) mod poly.
REQ-014 i_first and i_last on the same word SHALL form a single-word frame.
REQ-015 i_first on a word accepted while a frame is open SHALL discard the partial CRC and restart from i_init.
REQ-016 Inputs SHALL be ignored while o_ready=0.
REQ-017 A word accepted after reset without i_first SHALL continue from CRC 0 with the reset polynomial 0.

Reset
REQ-018 When i_rst_n=0 on an edge, the block SHALL go to IDLE and clear the CRC register, polynomial register, shift register, counter and latched i_last to 0.
REQ-019 Reset SHALL take effect in any state and SHALL discard any in-flight word or held result.
REQ-020 Output values during reset SHALL be: o_ready=0 while i_rst_n=0 and 1 after release; o_valid=0; o_crc=0; o_match=0.

Configuration
REQ-021 With macro CRC_CHECK_EN defined, the ports i_crc_ref and o_match SHALL exist, and o_match SHALL equal (o_crc == i_crc_ref) & o_valid.
REQ-022 With CRC_CHECK_EN undefined, the ports i_crc_ref and o_match and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-023 Package crc_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default WCODE/WPOLY/BPC constants.
REQ-024 The combinational BPC-bit LFSR update SHALL be the sub-module crc_step (inputs crc, data chunk, poly; output next crc).

Verification
REQ-025 The bench SHALL cover these directed scenarios (default parameters, poly 3'b101, init 0):
- Single word: i_data=4'b1101, i_first=i_last=1 -> o_valid 4 edges after accept, o_crc=2'b10.
- Two-word frame: 4'b1101 (first), then 4'b0000 (last) -> o_crc=2'b10; o_ready=0 during SHIFT and 1 between words.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_crc/o_valid stable; i_valid ignored; IDLE one edge after i_ready=1.
- Reset mid-SHIFT after 2 chunks: i_rst_n=0 one edge -> IDLE, o_crc=0; a new frame 4'b1101 gives 2'b10.
- Restart: i_first on the second word of an open frame, data 4'b1101 last -> o_crc=2'b10, first word discarded.
- CRC_CHECK_EN build: frame 4'b1101 with i_crc_ref=2'b10 -> o_match=1; with 2'b01 -> o_match=0.

Source files
------------

// File: rtl/crc_pkg.sv
// ============================================================================
// Module      : crc_pkg
// Description : Shared FSM state type and default widths for the CRC stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WCODE_DEF = 4;
  localparam int WPOLY_DEF = 3;
  localparam int BPC_DEF   = 1;

endpackage

`default_nettype wire

// File: rtl/crc_step.sv
// ============================================================================
// Module      : crc_step
// Description : Combinational BPC-bit LFSR update, MSB-first data chunk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_step #(
  parameter int WPOLY = 3,
  parameter int BPC   = 1
) (
  input  logic [WPOLY-2:0] i_crc,
  input  logic [BPC-1:0]   i_data,
  input  logic [WPOLY-2:0] i_poly,
  output logic [WPOLY-2:0] o_crc
);

  logic [WPOLY-2:0] w_crc;
  logic             w_fb;

  // The x^(WPOLY-1) term is implicit, so only the low polynomial bits are applied.
  always_comb begin
    w_crc = i_crc;
    w_fb  = 1'b0;
    for (int i = BPC - 1; i >= 0; i--) begin
      w_fb  = w_crc[WPOLY-2] ^ i_data[i];
      w_crc = (w_crc << 1) ^ (w_fb ? i_poly : '0);
    end
    o_crc = w_crc;
  end

endmodule

`default_nettype wire

// File: rtl/crc_stream.sv
// ============================================================================
// Module      : crc_stream
// Description : Word-serial streaming CRC with framing and result handshake.
//               Optional macro CRC_CHECK_EN adds i_crc_ref / o_match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_stream
  import crc_pkg::*;
#(
  parameter int WCODE = WCODE_DEF,
  parameter int WPOLY = WPOLY_DEF,
  parameter int BPC   = BPC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WCODE-1:0] i_data,
  input  logic             i_first,
  input  logic             i_last,
  input  logic [WPOLY-1:0] i_poly,
  input  logic [WPOLY-2:0] i_init,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_valid,
  input  logic             i_ready
`ifdef CRC_CHECK_EN
  ,
  input  logic [WPOLY-2:0] i_crc_ref,
  output logic             o_match
`endif
);

  localparam int c_nchunk = WCODE / BPC;
  localparam int c_cntw   = $clog2(c_nchunk + 1);

  if ((WCODE % BPC) != 0 || WPOLY < 2) begin : g_bad_params
    $fatal(1, "crc_stream: WCODE must be a multiple of BPC and WPOLY >= 2");
  end

  state_t              state_q, state_d;
  logic [WPOLY-2:0]    crc_q, crc_d;
  logic [WPOLY-2:0]    poly_q, poly_d;
  logic [WCODE-1:0]    shreg_q, shreg_d;
  logic [c_cntw-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [WPOLY-2:0]    w_crc_next;
  logic                unused_poly_msb;

  assign unused_poly_msb = i_poly[WPOLY-1];

  crc_step #(
    .WPOLY (WPOLY),
    .BPC   (BPC)
  ) u_step (
    .i_crc  (crc_q),
    .i_data (shreg_q[WCODE-1 -: BPC]),
    .i_poly (poly_q),
    .o_crc  (w_crc_next)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    poly_d  = poly_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          shreg_d = i_data;
          cnt_d   = c_cntw'(c_nchunk);
          last_d  = i_last;
          state_d = SHIFT;
          // Without i_first the frame continues on the held CRC and polynomial.
          if (i_first) begin
            crc_d  = i_init;
            poly_d = i_poly[WPOLY-2:0];
          end
        end
      end
      SHIFT: begin
        crc_d   = w_crc_next;
        shreg_d = shreg_q << BPC;
        cnt_d   = cnt_q - c_cntw'(1);
        if (cnt_q == c_cntw'(1)) begin
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      crc_q   <= '0;
      poly_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      poly_q  <= poly_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign o_ready = (state_q == IDLE) && i_rst_n;
  assign o_valid = (state_q == DONE);
  assign o_crc   = crc_q;

`ifdef CRC_CHECK_EN
  assign o_match = (o_crc == i_crc_ref) & o_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_stream.sv
// ============================================================================
// Module      : tb_crc_stream
// Description : Self-checking bench for crc_stream (directed + random traffic
//               against a polynomial long-division model). Honours CRC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_stream;

  localparam int W = 4;
  localparam int P = 3;
  localparam int R = P - 1;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_data = '0;
  logic         i_first = 1'b0;
  logic         i_last = 1'b0;
  logic [P-1:0] i_poly = 3'b101;
  logic [R-1:0] i_init = '0;
  logic [R-1:0] o_crc;
  logic         o_valid;
  logic         i_ready = 1'b0;
`ifdef CRC_CHECK_EN
  logic [R-1:0] i_crc_ref = '0;
  logic         o_match;
`endif

  int checks = 0;
  int failures = 0;

  crc_stream #(.WCODE(W), .WPOLY(P), .BPC(1)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_first   (i_first),
    .i_last    (i_last),
    .i_poly    (i_poly),
    .i_init    (i_init),
    .o_crc     (o_crc),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
`ifdef CRC_CHECK_EN
    ,
    .i_crc_ref (i_crc_ref),
    .o_match   (o_match)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Remainder of (message with seed xored onto its leading bits) * x^R mod poly.
  function automatic logic [R-1:0] crc_div(input logic [R-1:0] seed,
                                           input logic [R-1:0] plow,
                                           input bit bits[$]);
    bit d[$];
    logic [R:0] pf;
    logic [R-1:0] rem;
    int len;
    len = bits.size();
    d = bits;
    for (int k = 0; k < R; k++) d.push_back(1'b0);
    for (int j = 0; j < R; j++) d[j] ^= seed[R-1-j];
    pf = {1'b1, plow};
    for (int j = 0; j < len; j++)
      if (d[j]) for (int k = 0; k <= R; k++) d[j+k] ^= pf[R-k];
    for (int k = 0; k < R; k++) rem[R-1-k] = d[len+k];
    return rem;
  endfunction

  // Behavioural model: frame bit history plus a simple busy/done timeline.
  bit         model_on = 0;
  int         busy_left = 0;
  bit         m_done = 0;
  bit         m_last = 0;
  logic [R-1:0] m_seed = '0;
  logic [R-1:0] m_poly = '0;
  logic [R-1:0] m_crc = '0;
  bit         m_bits[$];

  always @(posedge clk) begin
    if (!i_rst_n) begin
      model_on = 1;
      busy_left = 0;
      m_done = 0;
      m_last = 0;
      m_seed = '0;
      m_poly = '0;
      m_crc = '0;
      m_bits.delete();
    end else if (model_on) begin
      if (m_done) begin
        if (i_ready) m_done = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0 && m_last) m_done = 1;
      end else if (i_valid) begin
        if (i_first) begin
          m_seed = i_init;
          m_poly = i_poly[R-1:0];
          m_bits.delete();
        end
        for (int k = W - 1; k >= 0; k--) m_bits.push_back(i_data[k]);
        m_crc = crc_div(m_seed, m_poly, m_bits);
        busy_left = N;
        m_last = i_last;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("ready", o_ready, i_rst_n && busy_left == 0 && !m_done);
      chk("valid", o_valid, m_done);
      if (busy_left == 0) chk("crc", o_crc, m_crc);
`ifdef CRC_CHECK_EN
      chk("match", o_match, m_done && (m_crc == i_crc_ref));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic f, input logic l);
    int n;
    n = 0;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_first = f;
    i_last  = l;
    tick();
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_sig(input bit want_valid, output int n);
    n = 0;
    while ((want_valid ? !o_valid : !o_ready) && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit pin_bits[$];
    pin_bits = '{1, 1, 0, 1};
    chk("model_pin0", crc_div(2'b00, 2'b01, pin_bits), 2'b10);
    chk("model_pin1", crc_div(2'b11, 2'b01, pin_bits), 2'b01);

    tick();
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("reset_ready", o_ready, 1);
    chk("reset_crc", o_crc, 0);
    chk("reset_valid", o_valid, 0);

    // Single-word frame with latency measurement, then backpressure.
    send(4'b1101, 1, 1);
    wait_sig(1, n);
    chk("single_latency", n, 4);
    chk("single_crc", o_crc, 2'b10);
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_data  = 4'($urandom);
      tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_crc", o_crc, 2'b10);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp_idle_ready", o_ready, 1);
    chk("bp_idle_valid", o_valid, 0);

    // Two-word frame.
    send(4'b1101, 1, 0);
    chk("two_busy", o_ready, 0);
    wait_sig(0, n);
    chk("two_gap_latency", n, 4);
    send(4'b0000, 0, 1);
    wait_sig(1, n);
    chk("two_crc", o_crc, 2'b10);
    release_result();

    // Reset after two chunks of an in-flight word.
    send(4'b0110, 1, 1);
    tick();
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("rst_low_ready", o_ready, 0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_crc", o_crc, 0);
    chk("rst_valid", o_valid, 0);
    send(4'b1101, 1, 1);
    wait_sig(1, n);
    chk("rst_new_crc", o_crc, 2'b10);
    release_result();

    // Restart: i_first mid-frame discards the partial CRC.
    send(4'b0111, 1, 0);
    wait_sig(0, n);
    send(4'b1101, 1, 1);
    wait_sig(1, n);
    chk("restart_crc", o_crc, 2'b10);
`ifdef CRC_CHECK_EN
    i_crc_ref = 2'b10;
    #1;
    chk("match_hit", o_match, 1);
    i_crc_ref = 2'b01;
    #1;
    chk("match_miss", o_match, 0);
`endif
    release_result();

    // After reset a word without i_first runs on seed 0 and poly 0.
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    i_poly = 3'b111;
    i_init = 2'b11;
    send(4'b1101, 0, 1);
    wait_sig(1, n);
    chk("nofirst_crc", o_crc, 2'b00);
    release_result();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      i_rst_n = ($urandom_range(0, 199) != 0);
      i_valid = $urandom_range(0, 1);
      i_data  = 4'($urandom);
      i_first = ($urandom_range(0, 3) == 0) || (m_bits.size() > 40);
      i_last  = ($urandom_range(0, 2) == 0);
      i_poly  = 3'($urandom);
      i_init  = 2'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
`ifdef CRC_CHECK_EN
      i_crc_ref = $urandom_range(0, 1) ? m_crc : 2'($urandom);
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
